mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter DATA_W, default 66, flit width: 2-bit type in [DATA_W-1:DATA_W-2] plus 64-bit payload.
REQ-002 Parameter VCH_W, default 2, virtual-channel ID width.
REQ-003 Parameter SEL_W, default 5, select-vector width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 idata_0  input  DATA_W  port-0 flit.
REQ-007 ivalid_0  input  1  port-0 flit valid.
REQ-008 ivch_0  input  VCH_W  port-0 virtual channel.
REQ-009 idata_1  input  DATA_W  port-1 flit.
REQ-010 ivalid_1  input  1  port-1 flit valid.
REQ-011 ivch_1  input  VCH_W  port-1 virtual channel.
REQ-012 sel  input  SEL_W  one-hot port select; bit0 = port 0, bit1 = port 1, bits [SEL_W-1:2] ignored.
REQ-013 odata  output  DATA_W  registered selected flit.
REQ-014 ovalid  output  1  registered selected valid.
REQ-015 ovch  output  VCH_W  registered selected virtual channel.

Function
REQ-016 Selection SHALL be combinational on sel, ivalid_x, idata_x and ivch_x; outputs SHALL register the selection at the next rising clk edge, giving 1-cycle latency.
REQ-017 sel[0]=1 SHALL select port 0 (odata<=idata_0, ovalid<=ivalid_0, ovch<=ivch_0).
REQ-018 sel[1]=1 with sel[0]=0 SHALL select port 1.
REQ-019 sel[0]=1 and sel[1]=1 together SHALL select port 0 (fixed priority).
REQ-020 sel[1:0]=00 SHALL register ovalid=0 and ovch=0; odata SHALL follow REQ-027/REQ-028.
REQ-021 Bits sel[SEL_W-1:2] SHALL have no effect on any output.
REQ-022 ovalid SHALL equal the registered ivalid of the selected port, with no flit-type interpretation; HEAD, DATA, TAIL and NONE flits SHALL pass unchanged.
REQ-023 There is no backpressure; every selected valid flit SHALL appear on the outputs exactly one cycle later, and back-to-back flits SHALL stream at one per cycle.
REQ-024 A change of sel SHALL take effect on the first clock edge after the change, without dropping or duplicating flits from the newly selected port.

Reset
REQ-025 While rst=1, odata, ovalid and ovch SHALL be 0 immediately, independent of clk.
REQ-026 After rst deasserts, the first rising edge SHALL capture the current selection; a reset asserted mid-packet SHALL discard the in-flight flit without recovering it.

Configuration
REQ-027 With macro MUX_DATA_GATE_EN defined, odata SHALL update only when the selected port's ivalid=1, and SHALL otherwise hold its previous value (ovalid/ovch still update) to suppress switching on idle cycles.
REQ-028 Without MUX_DATA_GATE_EN, odata SHALL register the selected idata every cycle regardless of valid, or 0 when sel[1:0]=00.

Verification
REQ-029 rst=1 with idata_1=all-ones, ivalid_1=1, sel=5'b00010 -> odata=0, ovalid=0, ovch=0 with no clock edge.
REQ-030 sel=5'b00010, idata_1={HEAD,32'h0,32'h04}, ivalid_1=1, ivch_1=2 -> next cycle odata={HEAD,32'h0,32'h04}, ovalid=1, ovch=2; port 0 traffic ignored.
REQ-031 sel=5'b00011, idata_0=66'h1, idata_1=66'h2, both valid -> odata=66'h1 (port-0 priority).
REQ-032 sel=5'b11100 with both ports valid -> ovalid=0, ovch=0.
REQ-033 sel=5'b00010, 20-flit stream of alternating 49-bit 0/1 run patterns, then TAIL, then ivalid_1=0 carrying idata_1=66'h3 -> every flit appears one cycle later in order; on the idle cycle odata holds TAIL when MUX_DATA_GATE_EN is defined, else odata=66'h3.
REQ-034 sel toggled 5'b00001 -> 5'b00010 mid-stream with both ports valid -> the output switches source on the first edge after the change, with no flit duplicated or lost.

Source files
------------

// File: rtl/mux.sv
// mux: two-port flit selector with fixed port-0 priority and registered outputs.
// Optional MUX_DATA_GATE_EN holds odata on idle cycles to cut switching.
module mux #(
  parameter int DATA_W = 66,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic [VCH_W-1:0]  vch_d, vch_q;
  logic              unused_sel;
  assign unused_sel = ^sel;
  always_comb begin
    data_d  = sel[0] ? idata_0  : sel[1] ? idata_1 : '0;
    valid_d = sel[0] ? ivalid_0 : sel[1] & ivalid_1;
    vch_d   = sel[0] ? ivch_0   : sel[1] ? ivch_1  : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      vch_q   <= '0;
    end else begin
      valid_q <= valid_d;
      vch_q   <= vch_d;
`ifdef MUX_DATA_GATE_EN
      if (valid_d) data_q <= data_d;
`else
      data_q  <= data_d;
`endif
    end
  end
  assign odata  = data_q;
  assign ovalid = valid_q;
  assign ovch   = vch_q;
endmodule

// File: tb/tb_mux.sv
// tb_mux: directed self-checking bench for mux.
module tb_mux;
  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11;
  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] idata_0, idata_1, odata;
  logic        ivalid_0, ivalid_1, ovalid;
  logic [1:0]  ivch_0, ivch_1, ovch;
  logic [4:0]  sel;
  logic [65:0] flit, tail_flit;
  int checks = 0;
  int errors = 0;

  mux dut (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 5'b00010;
    idata_0 = '0; ivalid_0 = 1'b0; ivch_0 = 2'd0;
    idata_1 = '1; ivalid_1 = 1'b1; ivch_1 = 2'd3;
    #2;
    chk("rst_odata", odata, 66'h0);
    chk("rst_ovalid", {65'h0, ovalid}, 66'h0);
    chk("rst_ovch", {64'h0, ovch}, 66'h0);
    rst = 1'b0;
    tick;
    chk("post_rst_odata", odata, '1);
    chk("post_rst_ovalid", {65'h0, ovalid}, 66'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_odata", odata, 66'h0);
    chk("async_rst_ovalid", {65'h0, ovalid}, 66'h0);
    chk("async_rst_ovch", {64'h0, ovch}, 66'h0);
    rst = 1'b0;
    // Port 1 selected, port 0 carries unrelated traffic.
    idata_1 = {HEAD, 32'h0, 32'h04}; ivalid_1 = 1'b1; ivch_1 = 2'd2;
    idata_0 = {DATA, 64'hDEAD_BEEF_0000_0001}; ivalid_0 = 1'b1; ivch_0 = 2'd1;
    tick;
    chk("p1_odata", odata, {HEAD, 32'h0, 32'h04});
    chk("p1_ovalid", {65'h0, ovalid}, 66'h1);
    chk("p1_ovch", {64'h0, ovch}, 66'h2);
    sel = 5'b00011; idata_0 = 66'h1; idata_1 = 66'h2; ivch_0 = 2'd1; ivch_1 = 2'd3;
    tick;
    chk("prio_odata", odata, 66'h1);
    chk("prio_ovch", {64'h0, ovch}, 66'h1);
    chk("prio_ovalid", {65'h0, ovalid}, 66'h1);
    sel = 5'b00001; ivalid_0 = 1'b0; idata_0 = 66'h5;
    tick;
    chk("p0_idle_ovalid", {65'h0, ovalid}, 66'h0);
`ifdef MUX_DATA_GATE_EN
    chk("p0_idle_odata", odata, 66'h1);
`else
    chk("p0_idle_odata", odata, 66'h5);
`endif
    sel = 5'b11100; ivalid_0 = 1'b1; ivalid_1 = 1'b1; idata_0 = 66'h7; idata_1 = 66'h9;
    tick;
    chk("nosel_ovalid", {65'h0, ovalid}, 66'h0);
    chk("nosel_ovch", {64'h0, ovch}, 66'h0);
`ifdef MUX_DATA_GATE_EN
    chk("nosel_odata", odata, 66'h1);
`else
    chk("nosel_odata", odata, 66'h0);
`endif
    // 20-flit stream, alternating 49-bit runs of ones/zeros tagged with index.
    sel = 5'b00010; ivch_1 = 2'd1; ivalid_1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      flit = {(i == 0) ? HEAD : DATA, 15'(i), (i % 2 == 0) ? 49'h1_FFFF_FFFF_FFFF : 49'h0};
      idata_1 = flit;
      tick;
      chk($sformatf("stream_odata_%0d", i), odata, flit);
      chk($sformatf("stream_ovalid_%0d", i), {65'h0, ovalid}, 66'h1);
    end
    tail_flit = {TAIL, 64'h0000_0000_0000_00AA};
    idata_1 = tail_flit;
    tick;
    chk("tail_odata", odata, tail_flit);
    ivalid_1 = 1'b0; idata_1 = 66'h3;
    tick;
    chk("idle_ovalid", {65'h0, ovalid}, 66'h0);
    chk("idle_ovch", {64'h0, ovch}, 66'h1);
`ifdef MUX_DATA_GATE_EN
    chk("idle_odata", odata, tail_flit);
`else
    chk("idle_odata", odata, 66'h3);
`endif
    // Switch source mid-stream.
    sel = 5'b00001; ivalid_0 = 1'b1; ivalid_1 = 1'b1; ivch_0 = 2'd1; ivch_1 = 2'd2;
    idata_0 = {NONE, 64'hA0}; idata_1 = {NONE, 64'hB0};
    tick;
    chk("sw_a0", odata, {NONE, 64'hA0});
    sel = 5'b00010; idata_0 = {DATA, 64'hA1}; idata_1 = {DATA, 64'hB1};
    tick;
    chk("sw_b1", odata, {DATA, 64'hB1});
    chk("sw_b1_ovch", {64'h0, ovch}, 66'h2);
    idata_0 = {DATA, 64'hA2}; idata_1 = {DATA, 64'hB2};
    tick;
    chk("sw_b2", odata, {DATA, 64'hB2});
    // Reset mid-packet drops the in-flight flit.
    idata_1 = {DATA, 64'hC0};
    #2 rst = 1'b1;
    #1;
    chk("midpkt_rst_odata", odata, 66'h0);
    tick;
    chk("midpkt_hold_odata", odata, 66'h0);
    chk("midpkt_hold_ovalid", {65'h0, ovalid}, 66'h0);
    rst = 1'b0; idata_1 = {TAIL, 64'hC1};
    tick;
    chk("midpkt_resume_odata", odata, {TAIL, 64'hC1});
    chk("midpkt_resume_ovalid", {65'h0, ovalid}, 66'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
